// File: rtl/snow_pkg.sv
// -----------------------------------------------------------------------------
// snow_pkg
// Shared definitions for the snowflake update sequencer.
//   - Default flake-word field widths and the field offset helpers. The word
//     layout is {spd[1:0], y, x}, with x in the least significant bits.
//   - Default wrap bounds (screen resolution).
//   - LFSR width and tap mask.
//   - Sequencer FSM state enum.
// No ports; imported by snow_flake_step and snow_flake_sched.
// -----------------------------------------------------------------------------
package snow_pkg;

    localparam int DEF_X_W   = 10;
    localparam int DEF_Y_W   = 10;
    localparam int SPD_W     = 2;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    // 16-bit Fibonacci LFSR with taps 16,14,13,11.
    // Those taps are bits 15,13,12,10 when counted from zero.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // The field offsets depend on the chosen coordinate widths.
    // They are computed through these helpers, so that every user agrees on
    // the layout.
    function automatic int xOffset();
        return 0;
    endfunction

    function automatic int yOffset(input int xw);
        return xw;
    endfunction

    function automatic int spdOffset(input int xw, input int yw);
        return xw + yw;
    endfunction

    function automatic int wordWidth(input int xw, input int yw);
        return SPD_W + xw + yw;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } schedState_e;

endpackage

// File: rtl/snow_flake_step.sv
// -----------------------------------------------------------------------------
// snow_flake_step
// Purely combinational next-position function for one snowflake.
// Ports:
//   word_i  in   old flake word {spd, y, x}
//   lfsr_i  in   current LFSR value (random source for respawn and drift)
//   word_o  out  updated flake word, same layout
// Rules:
//   - The flake falls by spd+1 rows.
//   - Reaching V_RES respawns the flake at the top:
//       * the new x comes from the LFSR, folded into 0..H_RES-1;
//       * the new speed comes from the LFSR.
//   - Otherwise x drifts by one column, wrapping at the screen edges.
//     LFSR bit 0 picks the drift direction.
// -----------------------------------------------------------------------------
module snow_flake_step
    import snow_pkg::*;
#(
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic [SPD_W+Y_W+X_W-1:0] word_i,
    input  logic [LFSR_W-1:0]        lfsr_i,
    output logic [SPD_W+Y_W+X_W-1:0] word_o
);

    localparam int X_LO = xOffset();
    localparam int Y_LO = yOffset(X_W);
    localparam int S_LO = spdOffset(X_W, Y_W);

    // Bounds are held one bit wider than the coordinates.
    // This lets sums reach or exceed the bound without wrapping.
    localparam logic [X_W:0] H_BOUND = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] V_BOUND = (Y_W+1)'(V_RES);

    logic [X_W-1:0]   xOld;
    logic [Y_W-1:0]   yOld;
    logic [SPD_W-1:0] sOld;

    logic [Y_W:0]     ySum;
    logic             respawn;
    logic [X_W:0]     xRand;
    logic [X_W:0]     xInc;
    logic [X_W:0]     xDec;
    logic [X_W:0]     xSel;
    logic [Y_W:0]     ySel;
    logic [SPD_W-1:0] sSel;

    assign xOld = word_i[X_LO +: X_W];
    assign yOld = word_i[Y_LO +: Y_W];
    assign sOld = word_i[S_LO +: SPD_W];

    // The fall distance and the three candidate x values are computed in
    // parallel. The respawn decision then selects which results are used.
    always_comb begin
        ySum    = {1'b0, yOld} + {{(Y_W+1-SPD_W){1'b0}}, sOld} + (Y_W+1)'(1);
        respawn = (ySum >= V_BOUND);

        // The raw LFSR slice can exceed H_RES-1 by less than H_RES.
        // A single subtraction therefore always lands the value on screen.
        xRand = {1'b0, lfsr_i[X_W-1:0]};
        if (xRand >= H_BOUND) begin
            xRand = xRand - H_BOUND;
        end

        xInc = {1'b0, xOld} + (X_W+1)'(1);
        if (xInc >= H_BOUND) begin
            xInc = '0;
        end

        if (xOld == '0) begin
            xDec = H_BOUND - (X_W+1)'(1);
        end else begin
            xDec = {1'b0, xOld} - (X_W+1)'(1);
        end

        if (respawn) begin
            ySel = '0;
            xSel = xRand;
            sSel = lfsr_i[LFSR_W-1 -: SPD_W];
        end else begin
            ySel = ySum;
            xSel = lfsr_i[0] ? xInc : xDec;
            sSel = sOld;
        end
    end

    assign word_o = {sSel, ySel[Y_W-1:0], xSel[X_W-1:0]};

    // The guard bits are never set after the range folding above.
    // The LFSR bits between the x slice and the speed slice play no role.
    logic unusedBits;
    assign unusedBits = ^{lfsr_i, xSel[X_W], ySel[Y_W]};

endmodule

// File: rtl/snow_flake_sched.sv
// -----------------------------------------------------------------------------
// snow_flake_sched
// Per-frame update sequencer for the snowflake position table.
// On each vblank pulse it walks every slot of the single-port table RAM.
// Each slot gets a read / wait / write cycle, and the write stores the
// stepped position. The pixel renderer shares the RAM port and always wins.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ena            design enable; low freezes the sequencer
//   vblank_start   one-cycle pulse that starts a sweep
//   rnd_req        renderer read request
//   rnd_addr       renderer slot address
//   rnd_gnt        renderer owns the RAM port this cycle
//   mem_addr       RAM address
//   mem_re         RAM read strobe; data is returned one cycle later
//   mem_we         RAM write strobe
//   mem_wdata      RAM write word {spd, y, x}
//   mem_rdata      RAM read word {spd, y, x}
//   busy           a sweep is in progress
//   overrun        sticky: a vblank arrived while a sweep was in progress
//   frame_cnt      number of completed sweeps, wraps at 8 bits
// -----------------------------------------------------------------------------
module snow_flake_sched
    import snow_pkg::*;
#(
    parameter int          NUM_FLAKES = 16,
    parameter int          X_W        = DEF_X_W,
    parameter int          Y_W        = DEF_Y_W,
    parameter int          H_RES      = DEF_H_RES,
    parameter int          V_RES      = DEF_V_RES,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         SLOT_W     = $clog2(NUM_FLAKES),
    localparam int         WORD_W     = SPD_W + Y_W + X_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              vblank_start,
    input  logic              rnd_req,
    input  logic [SLOT_W-1:0] rnd_addr,
    output logic              rnd_gnt,
    output logic [SLOT_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_FLAKES - 1);

    schedState_e       state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [7:0]        frameCnt_q, frameCnt_d;
    logic              overrun_q, overrun_d;

    logic [WORD_W-1:0] stepWord;
    logic [LFSR_W-1:0] lfsrNext;

    snow_flake_step #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_step (
        .word_i (rdata_q),
        .lfsr_i (lfsr_q),
        .word_o (stepWord)
    );

    assign lfsrNext = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

    // The renderer grant is combinational and also masked by reset.
    // As a result, the RAM port is fully quiet while rst_n is low.
    assign rnd_gnt = rnd_req & ena & rst_n;

    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;
    assign frame_cnt = frameCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            rdata_q    <= '0;
            frameCnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            lfsr_q     <= lfsr_d;
            rdata_q    <= rdata_d;
            frameCnt_q <= frameCnt_d;
            overrun_q  <= overrun_d;
        end
    end

    // RAM port mux and sweep sequencing.
    // A grant to the renderer blocks the RD and WR strobes, so those states
    // simply repeat. WAIT always advances: its data was fetched by the
    // sequencer's own read in the previous cycle, so a renderer read now
    // cannot disturb it.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        lfsr_d     = lfsr_q;
        rdata_d    = rdata_q;
        frameCnt_d = frameCnt_q;
        overrun_d  = overrun_q;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        if (rnd_gnt) begin
            mem_addr = rnd_addr;
            mem_re   = 1'b1;
        end

        if (ena) begin
            if (vblank_start && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (vblank_start) begin
                        state_d = ST_RD;
                        slot_d  = '0;
                    end
                end

                ST_RD: begin
                    if (!rnd_gnt) begin
                        mem_re   = 1'b1;
                        mem_addr = slot_q;
                        state_d  = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    rdata_d = mem_rdata;
                    state_d = ST_WR;
                end

                ST_WR: begin
                    if (!rnd_gnt) begin
                        mem_we    = 1'b1;
                        mem_addr  = slot_q;
                        mem_wdata = stepWord;
                        lfsr_d    = lfsrNext;
                        if (slot_q == LAST_SLOT) begin
                            state_d = ST_DONE;
                        end else begin
                            slot_d  = slot_q + SLOT_W'(1);
                            state_d = ST_RD;
                        end
                    end
                end

                ST_DONE: begin
                    frameCnt_d = frameCnt_q + 8'd1;
                    state_d    = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snow_flake_sched.sv
`timescale 1ns/1ps
module tb_snow_flake_sched;

    localparam int          NF   = 4;
    localparam int          XW   = 10;
    localparam int          YW   = 10;
    localparam int          WW   = 2 + YW + XW;
    localparam int          SW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b1;
    logic          ena          = 1'b0;
    logic          vblank_start = 1'b0;
    logic          rnd_req      = 1'b0;
    logic [SW-1:0] rnd_addr     = '0;
    logic          rnd_gnt;
    logic [SW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;
    logic          busy;
    logic          overrun;
    logic [7:0]    frame_cnt;

    int errCnt   = 0;
    int checkCnt = 0;

    always #5 clk = ~clk;

    snow_flake_sched #(
        .NUM_FLAKES (NF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .vblank_start (vblank_start),
        .rnd_req      (rnd_req),
        .rnd_addr     (rnd_addr),
        .rnd_gnt      (rnd_gnt),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .overrun      (overrun),
        .frame_cnt    (frame_cnt)
    );

    // Single-port table RAM with one-cycle read latency, plus a port monitor
    // logging sequencer-owned reads and all writes.
    logic [WW-1:0] ram [NF];
    logic [WW-1:0] ramRdata = '0;
    int cycleCnt  = 0;
    int firstRead = -1;
    int wrLog[$];
    int rdLog[$];

    assign mem_rdata = ramRdata;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) ramRdata <= ram[mem_addr];
        if (rst_n && mem_we) wrLog.push_back(int'(mem_addr));
        if (rst_n && mem_re && !rnd_gnt) begin
            rdLog.push_back(int'(mem_addr));
            if (firstRead < 0) firstRead <= cycleCnt;
        end
        cycleCnt <= cycleCnt + 1;
    end

    // Reference model state.
    logic [WW-1:0] orig [NF];
    logic [WW-1:0] expd [NF];
    logic [15:0]   modelLfsr  = SEED;
    int            frameModel = 0;
    int            startCycle = 0;

    function automatic logic [WW-1:0] mkWord(input int s, input int y, input int x);
        return {2'(s), 10'(y), 10'(x)};
    endfunction

    // One flake step computed directly from the screen rules with integers.
    function automatic logic [WW-1:0] refStep(input logic [WW-1:0] w, input logic [15:0] l);
        int x, y, s;
        x = int'(w[XW-1:0]);
        y = int'(w[XW+YW-1:XW]);
        s = int'(w[WW-1:WW-2]);
        y = y + s + 1;
        if (y >= 480) begin
            y = 0;
            x = int'(l) % 1024;
            if (x >= 640) x = x - 640;
            s = int'(l) / 16384;
        end else if (l[0]) begin
            x = (x + 1) % 640;
        end else begin
            x = (x + 639) % 640;
        end
        return mkWord(s, y, x);
    endfunction

    function automatic logic [15:0] refLfsr(input logic [15:0] l);
        int b;
        b = ((int'(l) >> 15) ^ (int'(l) >> 13) ^ (int'(l) >> 12) ^ (int'(l) >> 10)) & 1;
        return {l[14:0], b[0]};
    endfunction

    function automatic logic [WW-1:0] randWord();
        int y;
        y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(470, 479)) : int'($urandom_range(0, 479));
        return mkWord(int'($urandom_range(0, 3)), y, int'($urandom_range(0, 639)));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadSlot(input int i, input logic [WW-1:0] w);
        ram[i]  = w;
        orig[i] = w;
    endtask

    task automatic predictSweep();
        for (int i = 0; i < NF; i++) begin
            expd[i]   = refStep(orig[i], modelLfsr);
            modelLfsr = refLfsr(modelLfsr);
        end
    endtask

    task automatic checkTable(input string tag);
        for (int i = 0; i < NF; i++) begin
            checkOutput($sformatf("%s_slot%0d", tag, i), 64'(ram[i]), 64'(expd[i]));
        end
    endtask

    task automatic doReset(input bit checkIt);
        @(negedge clk);
        rst_n        = 1'b0;
        ena          = 1'b1;
        rnd_req      = checkIt;
        vblank_start = 1'b0;
        #1;
        if (checkIt) begin
            checkOutput("rst_busy", 64'(busy), 0);
            checkOutput("rst_overrun", 64'(overrun), 0);
            checkOutput("rst_frame", 64'(frame_cnt), 0);
            checkOutput("rst_gnt", 64'(rnd_gnt), 0);
            checkOutput("rst_re", 64'(mem_re), 0);
            checkOutput("rst_we", 64'(mem_we), 0);
            checkOutput("rst_addr", 64'(mem_addr), 0);
            checkOutput("rst_wdata", 64'(mem_wdata), 0);
        end
        @(negedge clk);
        rnd_req = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        modelLfsr  = SEED;
        frameModel = 0;
    endtask

    // Mode 0: quiet sweep.
    // Mode 1: random renderer traffic.
    // Mode 2: renderer holds the port for the first three cycles of RD.
    // Mode 3: a second vblank arrives mid-sweep.
    // Mode 4: ena drops for three cycles, with requests and a vblank pending.
    task automatic applyStimulus(input int mode, output int busyLen);
        int k;
        wrLog.delete();
        rdLog.delete();
        firstRead = -1;
        @(negedge clk);
        ena          = 1'b1;
        vblank_start = 1'b1;
        startCycle   = cycleCnt;
        @(negedge clk);
        vblank_start = 1'b0;
        busyLen = 0;
        k = 0;
        while (busy && busyLen < 400) begin
            case (mode)
                1: begin
                    rnd_req  = ($urandom_range(0, 2) == 0);
                    rnd_addr = SW'($urandom_range(0, NF - 1));
                end
                2: begin
                    rnd_req  = (k < 3);
                    rnd_addr = SW'(k);
                end
                3: vblank_start = (k == 4);
                4: begin
                    ena          = !(k >= 3 && k < 6);
                    rnd_req      = !ena;
                    vblank_start = (k == 4);
                end
                default: ;
            endcase
            #1;
            if (mode == 2 && k < 3) begin
                checkOutput("cont_gnt", 64'(rnd_gnt), 1);
                checkOutput("cont_addr", 64'(mem_addr), 64'(k));
            end
            if (mode == 4 && !ena) begin
                checkOutput("ena_gnt", 64'(rnd_gnt), 0);
                checkOutput("ena_re", 64'(mem_re), 0);
                checkOutput("ena_we", 64'(mem_we), 0);
            end
            busyLen++;
            k++;
            @(negedge clk);
        end
        rnd_req      = 1'b0;
        vblank_start = 1'b0;
        ena          = 1'b1;
        if (busyLen >= 400) checkOutput("sweep_timeout", 64'(busyLen), 0);
        frameModel = (frameModel + 1) & 255;
    endtask

    initial begin
        int len;
        int found;
        logic [15:0] l;
        int expX [NF];

        for (int i = 0; i < NF; i++) loadSlot(i, '0);

        // Zero table: one clean sweep.
        doReset(1'b1);
        predictSweep();
        applyStimulus(0, len);
        checkOutput("busy_len", 64'(len), 13);
        checkOutput("rd_count", 64'(rdLog.size()), 4);
        checkOutput("wr_count", 64'(wrLog.size()), 4);
        for (int i = 0; i < NF; i++) begin
            if (i < rdLog.size()) checkOutput($sformatf("rd_addr%0d", i), 64'(rdLog[i]), 64'(i));
            if (i < wrLog.size()) checkOutput($sformatf("wr_addr%0d", i), 64'(wrLog[i]), 64'(i));
            checkOutput($sformatf("y_one%0d", i), 64'(ram[i][XW+YW-1:XW]), 1);
        end
        checkOutput("first_read", 64'(firstRead - startCycle), 1);
        checkOutput("frame_one", 64'(frame_cnt), 1);
        checkTable("zero");

        // Respawn from the bottom row using the seed value.
        doReset(1'b0);
        loadSlot(0, mkWord(3, 478, 5));
        for (int i = 1; i < NF; i++) loadSlot(i, randWord());
        predictSweep();
        applyStimulus(0, len);
        checkOutput("respawn_word", 64'(ram[0]), 64'(mkWord(2, 0, 225)));
        checkTable("respawn");

        // Horizontal wrap: each slot sits at the edge its drift direction crosses.
        doReset(1'b0);
        for (int sweep = 0; sweep < 3; sweep++) begin
            l = modelLfsr;
            for (int i = 0; i < NF; i++) begin
                loadSlot(i, mkWord(int'($urandom_range(0, 3)), int'($urandom_range(0, 400)), l[0] ? 639 : 0));
                expX[i] = l[0] ? 0 : 639;
                l = refLfsr(l);
            end
            predictSweep();
            applyStimulus(0, len);
            for (int i = 0; i < NF; i++) begin
                checkOutput(expX[i] == 0 ? "wrap_up" : "wrap_down", 64'(ram[i][XW-1:0]), 64'(expX[i]));
            end
            checkTable("wrap");
        end

        // Renderer contention at the start of the sweep.
        doReset(1'b0);
        for (int i = 0; i < NF; i++) loadSlot(i, randWord());
        predictSweep();
        applyStimulus(2, len);
        checkOutput("cont_len", 64'(len), 16);
        checkOutput("cont_first_read", 64'(firstRead - startCycle), 4);
        checkTable("cont");

        // Second vblank mid-sweep.
        checkOutput("pre_overrun", 64'(overrun), 0);
        for (int i = 0; i < NF; i++) loadSlot(i, randWord());
        predictSweep();
        applyStimulus(3, len);
        checkOutput("ovr_len", 64'(len), 13);
        checkOutput("ovr_flag", 64'(overrun), 1);
        checkOutput("ovr_frame", 64'(frame_cnt), 64'(frameModel));
        checkTable("ovr");

        // Enable dropout.
        doReset(1'b0);
        for (int i = 0; i < NF; i++) loadSlot(i, randWord());
        predictSweep();
        applyStimulus(4, len);
        checkOutput("ena_len", 64'(len), 16);
        checkOutput("ena_overrun", 64'(overrun), 0);
        checkOutput("ena_frame", 64'(frame_cnt), 64'(frameModel));
        checkTable("ena");

        // Random renderer traffic over several frames.
        for (int sweep = 0; sweep < 4; sweep++) begin
            for (int i = 0; i < NF; i++) loadSlot(i, randWord());
            predictSweep();
            applyStimulus(1, len);
            checkOutput("rand_frame", 64'(frame_cnt), 64'(frameModel));
            checkTable("rand");
        end

        // Reset during the write of slot 2.
        doReset(1'b0);
        for (int i = 0; i < NF; i++) loadSlot(i, randWord());
        predictSweep();
        @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            if (mem_we && mem_addr == SW'(2)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("wr2_seen", 64'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_we", 64'(mem_we), 0);
        checkOutput("arst_re", 64'(mem_re), 0);
        checkOutput("arst_addr", 64'(mem_addr), 0);
        checkOutput("arst_wdata", 64'(mem_wdata), 0);
        checkOutput("arst_busy", 64'(busy), 0);
        checkOutput("arst_frame", 64'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("arst_slot0", 64'(ram[0]), 64'(expd[0]));
        checkOutput("arst_slot1", 64'(ram[1]), 64'(expd[1]));
        checkOutput("arst_slot2", 64'(ram[2]), 64'(orig[2]));
        checkOutput("arst_slot3", 64'(ram[3]), 64'(orig[3]));
        orig[0]    = expd[0];
        orig[1]    = expd[1];
        modelLfsr  = SEED;
        frameModel = 0;
        predictSweep();
        applyStimulus(0, len);
        checkOutput("post_rst_frame", 64'(frame_cnt), 1);
        checkTable("post_rst");

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/snow_flake_sched.md
Name: snow_flake_sched

Overview:
- Per-frame update sequencer for the snowflake position table in the snow demo.
- On each vertical-blank pulse it sweeps all flake slots with read-modify-write cycles on a single-port table RAM, advancing each flake's position.
- It shares that RAM port with the pixel renderer; the renderer always has priority.
- It sits between the VGA timing generator (vblank pulse), the renderer and the flake table RAM inside tt_um_snow.

Parameters:
- NUM_FLAKES, 16, number of table slots; power of two, 2..64.
- X_W, 10, x coordinate width.
- Y_W, 10, y coordinate width.
- H_RES, 640, horizontal wrap bound; x is kept in 0..H_RES-1.
- V_RES, 480, vertical wrap bound; y is kept in 0..V_RES-1.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  design enable; 0 stalls the FSM.
- vblank_start  in  1  one-cycle pulse at the start of vertical blank.
- rnd_req  in  1  renderer read request.
- rnd_addr  in  $clog2(NUM_FLAKES)  renderer slot address.
- rnd_gnt  out  1  renderer granted this cycle.
- mem_addr  out  $clog2(NUM_FLAKES)  RAM address.
- mem_re  out  1  RAM read strobe; read data is valid one cycle later.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  2+Y_W+X_W  write word {spd[1:0], y, x}.
- mem_rdata  in  2+Y_W+X_W  read word, same format.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky flag: a vblank pulse arrived while busy.
- frame_cnt  out  8  count of completed sweeps; wraps 255->0.

Behaviour:
- Reset (async, rst_n=0) forces:
  - FSM to IDLE; slot index 0; LFSR = LFSR_SEED.
  - busy, overrun, rnd_gnt, mem_re, mem_we = 0; mem_addr, mem_wdata, frame_cnt = 0.
- Reset mid-sweep aborts immediately. No write is completed afterwards. The table keeps partially updated contents.
- Arbitration (combinational):
  - rnd_gnt = rnd_req & ena.
  - While rnd_gnt=1: mem_addr = rnd_addr, mem_re = 1, and the FSM issues no strobe and holds its state.
  - A renderer request therefore stalls RD or WR by one cycle per cycle of request.
- FSM states:
  - IDLE: on vblank_start & ena, go to RD with slot index 0 and busy=1.
  - RD: when not preempted, mem_re=1, mem_addr=slot; go to WAIT.
  - WAIT: capture mem_rdata; go to WR. WAIT ignores preemption; the captured data is always the FSM's own read.
  - WR: when not preempted, mem_we=1, mem_addr=slot, mem_wdata=updated word, advance LFSR. If slot==NUM_FLAKES-1 go to DONE; else slot+1 and go to RD.
  - DONE: busy=0, frame_cnt+1; go to IDLE.
- Sweep latency with no contention: 3*NUM_FLAKES+1 cycles from the vblank pulse to busy falling.
- Update rule per slot (old word {s, y, x}, LFSR bits L):
  - y' = y + s + 1. If y' >= V_RES, then y' = 0 (respawn).
  - On respawn: x' = L[X_W-1:0]; if that is >= H_RES, subtract H_RES once. s' = L[15:14].
  - No respawn, drift: L[0]=1 gives x+1, wrapping H_RES-1 to 0; L[0]=0 gives x-1, wrapping 0 to H_RES-1. s' = s.
  - All arithmetic is done one bit wider than the operand, so there is no silent overflow.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts once per WR commit only.
- vblank_start while busy: ignored, and overrun is set to 1. overrun stays 1 until reset.
- ena=0: FSM holds its state, no strobes, rnd_gnt=0. vblank_start is ignored and does not set overrun.

Decomposition:
- snow_pkg holds:
  - the flake word field widths and offsets;
  - the FSM state enum (IDLE, RD, WAIT, WR, DONE);
  - LFSR_TAPS;
  - the default H_RES/V_RES constants.
- Sub-module snow_flake_step: purely combinational next-word function of (old word, LFSR). It can be unit-tested on its own.

Test Plan:
- Reset, NUM_FLAKES=4, RAM preloaded with zeros, one vblank pulse, no renderer activity:
  - 4 reads and 4 writes at addresses 0,1,2,3;
  - busy high for exactly 13 cycles;
  - frame_cnt=1;
  - every y'=1.
- Slot word {s=3, y=478, x=5}:
  - y' = 0 (respawn);
  - x' = LFSR_SEED[9:0] reduced mod 640 = 225 (0x0E1);
  - s' = LFSR_SEED[15:14] = 2.
- x=639, no respawn, L[0]=1: x' = 0. Then x=0, L[0]=0: x' = 639.
- rnd_req held for 3 cycles starting at the first RD:
  - rnd_gnt=1 with mem_addr=rnd_addr for those 3 cycles;
  - FSM read delayed by 3 cycles;
  - final table contents identical to the uncontended run.
- Second vblank pulse 5 cycles into a sweep: sweep completes normally, overrun=1, frame_cnt increments only once.
- rst_n pulsed low during the WR of slot 2: all outputs 0 asynchronously, busy=0, LFSR back to seed, slots 2..3 unmodified.
